down_counter_timer: RTL
=======================

Name: down_counter_timer

Overview:
- Programmable synchronous down-counter/timer; the down-counting complement of the team's up-counting ripple counter.
- Loads a start value, decrements once per enabled clock, and flags terminal count.
- Supports one-shot and periodic (auto-reload) modes.
- Used as a tick/interval generator alongside the up-counter in the counter library.

Parameters:
- W, 4, counter width in bits (W >= 2)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-low (sampled on rising edge of clk)
- load  input  1  load request; load_val is captured on this edge
- load_val  input  W  start value / reload value
- en  input  1  count enable; decrement only when 1
- mode  input  1  0 = one-shot, 1 = periodic; sampled every cycle
- q  output  W  current count (registered)
- tc  output  1  terminal-count pulse, one cycle, registered
- busy  output  1  1 while in RUN state

Behaviour:
- Reset, rst=0 at posedge:
  - q=0, tc=0, busy=0, reload register=0, state=IDLE.
  - Reset overrides load and en.
  - Reset mid-count aborts with no tc.
- States:
  - IDLE: not counting; q holds; en ignored.
  - RUN: counting.
- Priority each edge: rst, then load, then en.
- load=1:
  - q<=load_val; reload<=load_val; tc<=0.
  - load_val!=0 -> RUN. load_val==0 -> IDLE, no tc.
  - Load in RUN restarts the count.
  - Load on the same edge as a would-be terminal count suppresses that tc.
- RUN, en=0: q, state hold; tc<=0.
- RUN, en=1, q>1: q<=q-1; tc<=0.
- RUN, en=1, q==1 (terminal edge): tc<=1 for exactly one cycle.
  - mode=0: q<=0, state<=IDLE, busy deasserts in the same cycle tc asserts.
  - mode=1: q<=reload (0 is skipped), stay RUN. The period is exactly reload enabled cycles.
- Count never wraps below 0. An all-ones load_val counts 2^W-1 enabled cycles.
- Latency:
  - Outputs update on the edge following the inputs.
  - tc is high in the cycle after the edge where q was 1.
- mode change during RUN takes effect at the next terminal edge.
- busy is a pure decode of state, with no extra register delay.

Decomposition:
- Shared package counter_pkg:
  - state enum (IDLE, RUN);
  - MODE_ONESHOT / MODE_PERIODIC constants.
- Sub-module tff_sync: T flip-flop with synchronous active-low reset and a parallel-load input.
  - Instantiated W times.
  - Bit i toggles when counting and bits [i-1:0] are all 0 (down-count borrow chain).
  - Load and reload override the toggle.
- Top level holds the FSM, the reload register, tc, and terminal detect.

Test Plan:
1. rst=0 for 2 cycles with load=1, en=1 -> q=0, tc=0, busy=0 throughout; release -> still IDLE.
2. W=4, load 5, mode=0, en=1 constant -> q sequence 5,4,3,2,1,0; tc high one cycle, coincident with q=0; busy falls with tc; q stays 0 afterwards.
3. load 3, mode=1, en=1 for 10 cycles:
   - q sequence 3,2,1,3,2,1,3,2,1,3;
   - tc pulses every 3rd cycle;
   - q never shows 0.
4. load 6, en toggles 1,0,0,1,… -> q holds during en=0; tc arrives only after 6 enabled cycles.
5. Edge cases:
   - load 4, count to 2, then load 9 with en=1 on the same edge -> q=9, no tc, count restarts;
   - load 0 -> IDLE, no tc;
   - load 15 -> 15 enabled cycles to tc.
6. rst=0 asserted while q=1 and en=1 (would-be terminal edge) -> q=0, tc stays 0, busy=0.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and constants for the counter library.
package counter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/down_counter_timer_if.sv
// Control/status bundle for down_counter_timer.
interface down_counter_timer_if #(
  parameter int W = 4
);
  logic         load;
  logic [W-1:0] load_val;
  logic         en;
  logic         mode;
  logic [W-1:0] q;
  logic         tc;
  logic         busy;

  modport master (output load, load_val, en, mode, input q, tc, busy);
  modport slave  (input load, load_val, en, mode, output q, tc, busy);
endinterface

// File: rtl/tff_sync.sv
// T flip-flop with synchronous active-low reset and parallel load.
// Load wins over toggle.
module tff_sync (
  input  logic clk,
  input  logic rst,
  input  logic t_i,
  input  logic ld_i,
  input  logic d_i,
  output logic q_o
);

  logic q_q;

  // reset, then load, then toggle
  always_ff @(posedge clk) begin
    if (!rst)      q_q <= 1'b0;
    else if (ld_i) q_q <= d_i;
    else if (t_i)  q_q <= ~q_q;
  end

  assign q_o = q_q;

endmodule

// File: rtl/down_counter_timer.sv
// Programmable down-counter/timer, one-shot or periodic auto-reload.
// The count itself lives in a chain of T flip-flops; this level owns the
// IDLE/RUN FSM, the reload register and the terminal-count pulse.
module down_counter_timer
  import counter_pkg::*;
#(
  parameter int W = 4
) (
  input logic                 clk,
  input logic                 rst,
  down_counter_timer_if.slave bus
);

  state_e       state_q;
  logic [W-1:0] reload_q;
  logic         tc_q;
  logic [W-1:0] cnt_q;

  logic         step;        // a decrement is due this edge
  logic         term;        // this edge is a terminal edge (q==1)
  logic         reload_hit;  // periodic wrap back to the reload value
  logic         ld_all;
  logic [W-1:0] ld_val;
  logic [W-1:0] zero_below;  // bits [i-1:0] of the count are all zero

  // Count only in RUN with enable, and never on a load edge.
  assign step       = (state_q == RUN) && bus.en && !bus.load;
  assign term       = step && (cnt_q == W'(1));
  assign reload_hit = term && (bus.mode == MODE_PERIODIC);
  assign ld_all     = bus.load || reload_hit;
  assign ld_val     = bus.load ? bus.load_val : reload_q;

  // Down-count borrow chain: bit i flips when every lower bit is zero.
  // In one-shot mode the terminal step is just 1 -> 0, a plain decrement.
  assign zero_below[0] = 1'b1;
  for (genvar i = 1; i < W; i++) begin : g_borrow
    assign zero_below[i] = zero_below[i-1] & ~cnt_q[i-1];
  end

  for (genvar i = 0; i < W; i++) begin : g_bit
    tff_sync u_tff (
      .clk  (clk),
      .rst  (rst),
      .t_i  (step & zero_below[i]),
      .ld_i (ld_all),
      .d_i  (ld_val[i]),
      .q_o  (cnt_q[i])
    );
  end

  // FSM, reload register and registered terminal-count pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else if (bus.load) begin
      reload_q <= bus.load_val;
      tc_q     <= 1'b0;
      state_q  <= (bus.load_val != '0) ? RUN : IDLE;
    end else if (term) begin
      tc_q <= 1'b1;
      if (bus.mode == MODE_ONESHOT) state_q <= IDLE;
    end else begin
      tc_q <= 1'b0;
    end
  end

  assign bus.q    = cnt_q;
  assign bus.tc   = tc_q;
  assign bus.busy = (state_q == RUN);

endmodule
